// File: rtl/series_engine_arbiter_if.sv
// Requester/engine bundle shared by the series-engine arbiter and its clients.
// The arbiter takes the slave view; requesters and the engine take the master view.
interface series_engine_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_x;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_data;
    logic               resp_err;
    logic               eng_start;
    logic [DW-1:0]      eng_x;
    logic               eng_done;
    logic [DW-1:0]      eng_result;

    modport master (
        output req, req_x, eng_done, eng_result,
        input  gnt, resp_valid, resp_data, resp_err, eng_start, eng_x
    );

    modport slave (
        input  req, req_x, eng_done, eng_result,
        output gnt, resp_valid, resp_data, resp_err, eng_start, eng_x
    );
endinterface

// File: rtl/series_engine_arbiter.sv
// Round-robin arbiter sharing one series-evaluation engine among NREQ requesters.
// Define SERIES_ARB_WATCHDOG_EN to abort BUSY after TIMEOUT_CYC cycles with resp_err.
module series_engine_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 16,
    parameter int MIN_LAT     = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    series_engine_arbiter_if.slave  bus
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCW = $clog2(MIN_LAT + 1);
    localparam logic [PW-1:0]  LAST_IDX  = PW'(NREQ - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MIN_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_BUSY,
        S_RESP
    } state_t;

    state_t         state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  owner;
    logic [WCW-1:0] wait_cnt;
    logic [PW-1:0]  pick_idx;
    logic [PW-1:0]  scan_idx;
    logic           pick_found;

`ifdef SERIES_ARB_WATCHDOG_EN
    localparam int BCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BCW-1:0] BUSY_LAST = BCW'(TIMEOUT_CYC - 1);
    logic [BCW-1:0] busy_cnt;
    logic           resp_err_r;
    assign bus.resp_err = resp_err_r;
`else
    assign bus.resp_err = 1'b0;
    // TIMEOUT_CYC has no effect without the watchdog; this empty guard only references it.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // Scan upward from rr_ptr with wrap-around; first requesting index wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && bus.req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            wait_cnt       <= '0;
            bus.gnt        <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            bus.eng_start  <= 1'b0;
            bus.eng_x      <= '0;
`ifdef SERIES_ARB_WATCHDOG_EN
            busy_cnt       <= '0;
            resp_err_r     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        owner         <= pick_idx;
                        bus.gnt       <= NREQ'(1) << pick_idx;
                        bus.eng_x     <= bus.req_x[pick_idx*DW +: DW];
                        bus.eng_start <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    bus.eng_start <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= S_WAIT;
                end
                // eng_done is not trustworthy until MIN_LAT cycles have passed.
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
`ifdef SERIES_ARB_WATCHDOG_EN
                    busy_cnt <= '0;
`endif
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.eng_done) begin
                        bus.resp_data  <= bus.eng_result;
                        bus.resp_valid <= NREQ'(1) << owner;
                        state          <= S_RESP;
                    end
`ifdef SERIES_ARB_WATCHDOG_EN
                    else if (busy_cnt == BUSY_LAST) begin
                        bus.resp_data  <= '1;
                        bus.resp_valid <= NREQ'(1) << owner;
                        resp_err_r     <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    bus.resp_valid <= '0;
                    bus.gnt        <= '0;
                    rr_ptr         <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    state          <= S_IDLE;
`ifdef SERIES_ARB_WATCHDOG_EN
                    resp_err_r     <= 1'b0;
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_series_engine_arbiter.sv
// Directed bench for series_engine_arbiter: round-robin order, latency, reset and timeout.
module tb_series_engine_arbiter;
    localparam int NREQ        = 4;
    localparam int DW          = 16;
    localparam int MIN_LAT     = 3;
    localparam int TIMEOUT_CYC = 8;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   n;
    int   starts;
    int   early;

    series_engine_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    series_engine_arbiter #(
        .NREQ(NREQ), .DW(DW), .MIN_LAT(MIN_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int idx, input logic [DW-1:0] val);
        bus.req_x[idx*DW +: DW] = val;
    endtask

    // Counts cycles until resp_valid appears, bounded at 40.
    task automatic wait_resp(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.resp_valid == '0 && cycles < 40);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req        = '0;
        bus.req_x      = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        tick();
        tick();
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_resp_data", 32'(bus.resp_data), 0);
        check("rst_resp_err", 32'(bus.resp_err), 0);
        check("rst_eng_start", 32'(bus.eng_start), 0);
        check("rst_eng_x", 32'(bus.eng_x), 0);
        rst = 1'b0;

        // All four requesting, eng_done held high throughout: order 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) set_x(i, 16'h1000 + 16'(i));
        bus.req      = 4'b1111;
        bus.eng_done = 1'b1;
        for (int j = 0; j < 5; j++) begin
            int exp_own;
            exp_own = j % NREQ;
            bus.eng_result = 16'h2000 + 16'(exp_own);
            n = 0;
            do begin
                tick();
                n++;
            end while (!bus.eng_start && n < 10);
            check($sformatf("rr_gap_%0d", j), n, (j == 0) ? 1 : 2);
            check($sformatf("rr_gnt_%0d", j), 32'(bus.gnt), 32'(1) << exp_own);
            check($sformatf("rr_eng_x_%0d", j), 32'(bus.eng_x), 32'h1000 + exp_own);
            starts = 0;
            n = 0;
            do begin
                tick();
                n++;
                starts += int'(bus.eng_start);
            end while (bus.resp_valid == '0 && n < 20);
            check($sformatf("rr_latency_%0d", j), n, MIN_LAT + 2);
            check($sformatf("rr_extra_start_%0d", j), starts, 0);
            check($sformatf("rr_resp_valid_%0d", j), 32'(bus.resp_valid), 32'(1) << exp_own);
            check($sformatf("rr_resp_data_%0d", j), 32'(bus.resp_data), 32'h2000 + exp_own);
        end
        bus.req      = '0;
        bus.eng_done = 1'b0;
        tick();
        check("rr_resp_one_cycle", 32'(bus.resp_valid), 0);
        check("rr_gnt_clear", 32'(bus.gnt), 0);

        // Single request from requester 0 (rr_ptr=1 wraps), req dropped mid-job, done after 10 cycles.
        set_x(0, 16'h0200);
        bus.eng_result = 16'h1234;
        bus.req = 4'b0001;
        tick();
        check("single_start", 32'(bus.eng_start), 1);
        check("single_gnt", 32'(bus.gnt), 32'h1);
        check("single_eng_x", 32'(bus.eng_x), 32'h0200);
        bus.req = '0;
        starts = 0;
        early  = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            starts += int'(bus.eng_start);
            early  += int'(bus.resp_valid != '0);
        end
        bus.eng_done = 1'b1;
        tick();
        check("single_extra_start", starts, 0);
        check("single_early_resp", early, 0);
        check("single_resp_valid", 32'(bus.resp_valid), 32'h1);
        check("single_resp_data", 32'(bus.resp_data), 32'h1234);
        check("single_resp_err", 32'(bus.resp_err), 0);
        check("single_eng_x_hold", 32'(bus.eng_x), 32'h0200);
        bus.eng_done = 1'b0;
        tick();
        check("single_resp_pulse", 32'(bus.resp_valid), 0);
        check("single_gnt_clear", 32'(bus.gnt), 0);

        // req_x changes after grant: eng_x keeps the latched operand.
        set_x(3, 16'h0AAA);
        bus.eng_result = 16'h0777;
        bus.req = 4'b1000;
        tick();
        check("hold_gnt", 32'(bus.gnt), 32'h8);
        check("hold_eng_x_start", 32'(bus.eng_x), 32'h0AAA);
        set_x(3, 16'h5555);
        tick();
        tick();
        tick();
        check("hold_eng_x_wait", 32'(bus.eng_x), 32'h0AAA);
        bus.eng_done = 1'b1;
        wait_resp(n);
        check("hold_latency", n, 2);
        check("hold_resp_valid", 32'(bus.resp_valid), 32'h8);
        check("hold_resp_data", 32'(bus.resp_data), 32'h0777);
        check("hold_eng_x_resp", 32'(bus.eng_x), 32'h0AAA);
        bus.eng_done = 1'b0;
        bus.req = '0;
        tick();

        // eng_done held high from START: accepted only once BUSY is reached.
        set_x(1, 16'h0033);
        bus.eng_result = 16'hBEEF;
        bus.eng_done = 1'b1;
        bus.req = 4'b0010;
        tick();
        check("early_done_start", 32'(bus.eng_start), 1);
        check("early_done_gnt", 32'(bus.gnt), 32'h2);
        wait_resp(n);
        check("early_done_latency", n, MIN_LAT + 2);
        check("early_done_resp_valid", 32'(bus.resp_valid), 32'h2);
        check("early_done_resp_data", 32'(bus.resp_data), 32'hBEEF);
        bus.eng_done = 1'b0;
        bus.req = '0;
        tick();

        // rr_ptr=2 here: req=0110 grants 2; reset in BUSY must bring rr_ptr back to 0.
        set_x(1, 16'h0111);
        set_x(2, 16'h0222);
        bus.req = 4'b0110;
        tick();
        check("rst_mid_gnt_before", 32'(bus.gnt), 32'h4);
        check("rst_mid_eng_x_before", 32'(bus.eng_x), 32'h0222);
        for (int k = 0; k < 4; k++) tick();
        check("rst_mid_no_resp_yet", 32'(bus.resp_valid), 0);
        rst = 1'b1;
        tick();
        check("rst_mid_gnt", 32'(bus.gnt), 0);
        check("rst_mid_eng_start", 32'(bus.eng_start), 0);
        check("rst_mid_eng_x", 32'(bus.eng_x), 0);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_mid_resp_data", 32'(bus.resp_data), 0);
        check("rst_mid_resp_err", 32'(bus.resp_err), 0);
        rst = 1'b0;
        tick();
        check("rst_mid_regrant_gnt", 32'(bus.gnt), 32'h2);
        check("rst_mid_regrant_start", 32'(bus.eng_start), 1);
        check("rst_mid_regrant_eng_x", 32'(bus.eng_x), 32'h0111);
        bus.eng_result = 16'h4321;
        bus.eng_done = 1'b1;
        wait_resp(n);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'h2);
        check("rst_mid_resp_data_after", 32'(bus.resp_data), 32'h4321);
        bus.eng_done = 1'b0;
        bus.req = '0;
        tick();

        // Engine never finishes.
        set_x(2, 16'h0042);
        bus.req = 4'b0100;
        tick();
        check("stall_gnt", 32'(bus.gnt), 32'h4);
`ifdef SERIES_ARB_WATCHDOG_EN
        wait_resp(n);
        check("wdog_latency", n, 1 + MIN_LAT + TIMEOUT_CYC);
        check("wdog_resp_valid", 32'(bus.resp_valid), 32'h4);
        check("wdog_resp_err", 32'(bus.resp_err), 1);
        check("wdog_resp_data", 32'(bus.resp_data), 32'hFFFF);
        bus.req = '0;
        tick();
        check("wdog_err_clear", 32'(bus.resp_err), 0);
`else
        early = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            early += int'(bus.resp_valid != '0);
        end
        check("stall_no_resp", early, 0);
        check("stall_gnt_held", 32'(bus.gnt), 32'h4);
        check("stall_resp_err", 32'(bus.resp_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
